box_spawn_scheduler: RTL and testbench

//  Round sequencer for the box game. Advances the 3-bit LFSR and maps its value to a box number 1..4.

---
 rtl/box_spawn_scheduler_pkg.sv | 17 +
 rtl/box_spawn_scheduler_if.sv | 21 ++
 rtl/box_spawn_scheduler_tick_prescaler.sv | 17 +
 rtl/box_spawn_scheduler.sv | 73 +++++++
 tb/tb_box_spawn_scheduler.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/box_spawn_scheduler_pkg.sv
// box_spawn_scheduler_pkg: state encodings, box constants and the LFSR-to-box mapping for the box game
package box_spawn_scheduler_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRAW = 3'd1;
  localparam logic [2:0] S_SHOW = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] BOX_NONE = 3'd0;
  localparam logic [2:0] BOX_MIN  = 3'd1;
  localparam logic [2:0] BOX_MAX  = 3'd4;
  function automatic logic [2:0] map_box(input logic [2:0] v);
    return v <= 3'd2 ? 3'd1 : v == 3'd3 ? 3'd2 : v <= 3'd5 ? 3'd3 : 3'd4;
  endfunction
  function automatic logic [2:0] next_box(input logic [2:0] b);
    return b == BOX_MAX ? BOX_MIN : b + 3'd1;
  endfunction
endpackage

// File: rtl/box_spawn_scheduler_if.sv
// box_spawn_scheduler_if: game-control bundle between the round sequencer and its surroundings
//   start/lfsr_value/hit_valid/hit_box flow into the scheduler (slave);
//   lfsr_enable/active_box/box_valid/score/misses/round_cnt/busy/done flow out.
interface box_spawn_scheduler_if;
  logic       start;
  logic [2:0] lfsr_value;
  logic       lfsr_enable;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic [2:0] active_box;
  logic       box_valid;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] round_cnt;
  logic       busy;
  logic       done;
  modport master (output start, lfsr_value, hit_valid, hit_box,
                  input lfsr_enable, active_box, box_valid, score, misses, round_cnt, busy, done);
  modport slave (input start, lfsr_value, hit_valid, hit_box,
                 output lfsr_enable, active_box, box_valid, score, misses, round_cnt, busy, done);
endinterface

// File: rtl/box_spawn_scheduler_tick_prescaler.sv
// tick_prescaler: free-running modulo-TICK_DIV counter emitting a one-cycle tick on wrap
//   CLOCK_50 in clock, reset in async active-high, clr in restart count at 0, tick out wrap pulse
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/box_spawn_scheduler.sv
// box_spawn_scheduler: round sequencer drawing a box from the LFSR, timing its window and scoring hit/miss
//   CLOCK_50 in clock, reset in async active-high, bus slave modport of box_spawn_scheduler_if
//   Optional macro NO_REPEAT_EN: never draw the same box in two consecutive rounds.
module box_spawn_scheduler
  import box_spawn_scheduler_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int ACTIVE_TICKS = 750,
  parameter int GAP_TICKS    = 250,
  parameter int ROUNDS       = 16
) (
  input logic CLOCK_50,
  input logic reset,
  box_spawn_scheduler_if.slave bus
);
  logic [2:0]  state, drawn;
  logic [15:0] tcnt;
  logic        tick, clr, go, hit, tmo, gap_end;
  assign go      = bus.start && (state == S_IDLE || state == S_DONE);
  assign hit     = state == S_SHOW && bus.hit_valid && bus.hit_box == bus.active_box;
  assign tmo     = state == S_SHOW && tick && tcnt == 16'(ACTIVE_TICKS - 1);
  assign gap_end = state == S_GAP && tick && tcnt == 16'(GAP_TICKS - 1);
  // clearing on the cycle before SHOW/GAP makes the first window cycle see count 0
  assign clr     = state == S_DRAW || hit || tmo;
  assign bus.lfsr_enable = state == S_DRAW;
  assign bus.box_valid   = state == S_SHOW;
  assign bus.busy        = state == S_DRAW || state == S_SHOW || state == S_GAP;
  assign bus.done        = state == S_DONE;
`ifdef NO_REPEAT_EN
  logic [2:0] prev_box;
  assign drawn = map_box(bus.lfsr_value) == prev_box ? next_box(prev_box) : map_box(bus.lfsr_value);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) prev_box <= BOX_NONE;
    else if (go) prev_box <= BOX_NONE;
    else if (state == S_DRAW) prev_box <= drawn;
`else
  assign drawn = map_box(bus.lfsr_value);
`endif
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .clr(clr),
    .tick(tick)
  );
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) tcnt <= '0;
    else if (clr) tcnt <= '0;
    else if (tick) tcnt <= tcnt + 16'd1;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state         <= S_IDLE;
      bus.active_box <= BOX_NONE;
      bus.score     <= '0;
      bus.misses    <= '0;
      bus.round_cnt <= '0;
    end else if (go) begin
      state         <= S_DRAW;
      bus.score     <= '0;
      bus.misses    <= '0;
      bus.round_cnt <= '0;
    end else if (state == S_DRAW) begin
      state          <= S_SHOW;
      bus.active_box <= drawn;
    end else if (hit || tmo) begin
      state          <= S_GAP;
      bus.active_box <= BOX_NONE;
      bus.round_cnt  <= bus.round_cnt + 8'd1;
      if (hit && bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
      if (!hit && bus.misses != 8'hFF) bus.misses <= bus.misses + 8'd1;
    end else if (gap_end) begin
      state <= bus.round_cnt == 8'(ROUNDS) ? S_DONE : S_DRAW;
    end
endmodule

// File: tb/tb_box_spawn_scheduler.sv
// tb_box_spawn_scheduler: directed self-checking bench for box_spawn_scheduler (TICK_DIV=4, ACTIVE_TICKS=5, GAP_TICKS=2, ROUNDS=3)
module tb_box_spawn_scheduler;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  box_spawn_scheduler_if bus ();
  box_spawn_scheduler #(.TICK_DIV(4), .ACTIVE_TICKS(5), .GAP_TICKS(2), .ROUNDS(3)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
`ifdef NO_REPEAT_EN
  localparam logic [2:0] REPEAT_BOX = 3'd1;
`else
  localparam logic [2:0] REPEAT_BOX = 3'd4;
`endif
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".lfsr_enable"}, 8'(bus.lfsr_enable), 8'd0);
    chk({tag, ".active_box"}, 8'(bus.active_box), 8'd0);
    chk({tag, ".box_valid"}, 8'(bus.box_valid), 8'd0);
    chk({tag, ".score"}, bus.score, 8'd0);
    chk({tag, ".misses"}, bus.misses, 8'd0);
    chk({tag, ".round_cnt"}, bus.round_cnt, 8'd0);
    chk({tag, ".busy"}, 8'(bus.busy), 8'd0);
    chk({tag, ".done"}, 8'(bus.done), 8'd0);
  endtask
  initial begin
    bus.start = 0; bus.lfsr_value = 3'b011; bus.hit_valid = 0; bus.hit_box = 0;
    step(2);
    chk_zero("reset");
    reset = 0;
    step(1);
    // round 1: lfsr 011 -> box 2
    bus.start = 1;
    step(1);
    bus.start = 0;
    chk("draw.lfsr_enable", 8'(bus.lfsr_enable), 8'd1);
    chk("draw.busy", 8'(bus.busy), 8'd1);
    chk("draw.box_valid", 8'(bus.box_valid), 8'd0);
    step(1);
    chk("show1.active_box", 8'(bus.active_box), 8'd2);
    chk("show1.box_valid", 8'(bus.box_valid), 8'd1);
    chk("show1.lfsr_enable", 8'(bus.lfsr_enable), 8'd0);
    bus.hit_valid = 1; bus.hit_box = 4;
    step(1);
    bus.hit_box = 2;
    chk("wrong_hit.box_valid", 8'(bus.box_valid), 8'd1);
    chk("wrong_hit.score", bus.score, 8'd0);
    step(1);
    bus.hit_valid = 0;
    chk("hit.score", bus.score, 8'd1);
    chk("hit.box_valid", 8'(bus.box_valid), 8'd0);
    chk("hit.active_box", 8'(bus.active_box), 8'd0);
    chk("hit.round_cnt", bus.round_cnt, 8'd1);
    // GAP: start ignored while busy, window is 8 cycles
    bus.start = 1;
    step(1);
    bus.start = 0;
    chk("busy_start.round_cnt", bus.round_cnt, 8'd1);
    chk("busy_start.score", bus.score, 8'd1);
    bus.lfsr_value = 3'b110;
    step(6);
    chk("gap_end.busy", 8'(bus.busy), 8'd1);
    chk("gap_end.lfsr_enable", 8'(bus.lfsr_enable), 8'd0);
    step(1);
    chk("draw2.lfsr_enable", 8'(bus.lfsr_enable), 8'd1);
    step(1);
    chk("show2.active_box", 8'(bus.active_box), 8'd4);
    // round 2: timeout after exactly 20 cycles
    step(19);
    chk("pre_timeout.misses", bus.misses, 8'd0);
    chk("pre_timeout.box_valid", 8'(bus.box_valid), 8'd1);
    step(1);
    chk("timeout.misses", bus.misses, 8'd1);
    chk("timeout.round_cnt", bus.round_cnt, 8'd2);
    chk("timeout.box_valid", 8'(bus.box_valid), 8'd0);
    step(8);
    chk("draw3.lfsr_enable", 8'(bus.lfsr_enable), 8'd1);
    step(1);
    chk("show3.active_box", 8'(bus.active_box), 8'(REPEAT_BOX));
    bus.hit_valid = 1; bus.hit_box = REPEAT_BOX;
    step(1);
    bus.hit_valid = 0;
    chk("hit3.score", bus.score, 8'd2);
    chk("hit3.round_cnt", bus.round_cnt, 8'd3);
    step(8);
    chk("done.done", 8'(bus.done), 8'd1);
    chk("done.busy", 8'(bus.busy), 8'd0);
    chk("done.round_cnt", bus.round_cnt, 8'd3);
    chk("done.misses", bus.misses, 8'd1);
    bus.hit_valid = 1; bus.hit_box = 0;
    step(1);
    bus.hit_valid = 0;
    chk("done_hit.score", bus.score, 8'd2);
    chk("done_hold.done", 8'(bus.done), 8'd1);
    // second game: lfsr 110 twice, hit coinciding with timeout
    bus.start = 1;
    step(1);
    bus.start = 0;
    chk("restart.lfsr_enable", 8'(bus.lfsr_enable), 8'd1);
    chk("restart.score", bus.score, 8'd0);
    chk("restart.misses", bus.misses, 8'd0);
    chk("restart.round_cnt", bus.round_cnt, 8'd0);
    chk("restart.done", 8'(bus.done), 8'd0);
    step(1);
    chk("g2r1.active_box", 8'(bus.active_box), 8'd4);
    step(19);
    bus.hit_valid = 1; bus.hit_box = 4;
    step(1);
    bus.hit_valid = 0;
    chk("tie.score", bus.score, 8'd1);
    chk("tie.misses", bus.misses, 8'd0);
    step(9);
    chk("g2r2.active_box", 8'(bus.active_box), 8'(REPEAT_BOX));
    // reset mid-SHOW takes effect without a clock edge
    step(3);
    reset = 1;
    #1;
    chk_zero("mid_reset");
    step(1);
    reset = 0;
    bus.start = 1;
    step(1);
    bus.start = 0;
    chk("after_reset.lfsr_enable", 8'(bus.lfsr_enable), 8'd1);
    step(1);
    chk("after_reset.active_box", 8'(bus.active_box), 8'd4);
    chk("after_reset.round_cnt", bus.round_cnt, 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
